// File: rtl/fft8_pkg.sv
// Shared definitions for the 8-point FFT pipeline: sizes, controller states
// and the 3-bit bit-reversal used both on input staging and output reorder.
package fft8_pkg;

  localparam int N_PTS = 8;
  localparam int LOG2N = 3;

  typedef enum logic [2:0] {
    ST_FILL = 3'd0,
    ST_S1   = 3'd1,
    ST_S2   = 3'd2,
    ST_S3   = 3'd3,
    ST_HOLD = 3'd4
  } fsmState_e;

  // Reverse the three index bits, so sample n lands in slot bitrev3(n).
  function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] idx);
    return {idx[0], idx[1], idx[2]};
  endfunction

endpackage

// File: rtl/fft8_in_bank.sv
// Eight-slot sample bank feeding the butterfly stages. One write port
// addressed by slot number; all slots exposed on a flat read bus.
module fft8_in_bank
  import fft8_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                writeEn_i,
  input  logic [LOG2N-1:0]    writeAddr_i,
  input  logic [DW-1:0]       writeData_i,
  output logic [N_PTS*DW-1:0] bank_o
);

  logic [DW-1:0] slot_q [N_PTS];

  // Slot storage: cleared on reset, otherwise only the addressed slot updates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_PTS; i++) begin
        slot_q[i] <= '0;
      end
    end else if (writeEn_i) begin
      slot_q[writeAddr_i] <= writeData_i;
    end
  end

  // Flatten the slots so slot i occupies bits [i*DW +: DW].
  always_comb begin
    bank_o = '0;
    for (int i = 0; i < N_PTS; i++) begin
      bank_o[i*DW +: DW] = slot_q[i];
    end
  end

endmodule

// File: rtl/fft8_seq_ctrl.sv
// Front-end sequencer for the 8-point FFT: collects a frame of samples in
// bit-reversed slot order, then pulses the three butterfly enables in turn
// and holds out_valid until the result is taken downstream.
module fft8_seq_ctrl
  import fft8_pkg::*;
#(
  parameter int DW  = 16,
  parameter int FCW = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [DW-1:0]       in_data,
  output logic                in_ready,
  output logic [N_PTS*DW-1:0] x_buf,
  output logic                bf1_en,
  output logic                bf2_en,
  output logic                bf3_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FCW-1:0]      frame_cnt,
  output logic                busy
);

  fsmState_e        state_q, state_d;
  logic [LOG2N-1:0] sampleCnt_q, sampleCnt_d;
  logic [FCW-1:0]   frameCnt_q, frameCnt_d;
  logic             bf1En_q, bf2En_q, bf3En_q, outValid_q;
  logic             bankWrite;

  // State, sample counter and frame counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_FILL;
      sampleCnt_q <= '0;
      frameCnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      sampleCnt_q <= sampleCnt_d;
      frameCnt_q  <= frameCnt_d;
    end
  end

  // Next-state logic; flush overrides sample accept and result consume.
  always_comb begin
    state_d     = state_q;
    sampleCnt_d = sampleCnt_q;
    frameCnt_d  = frameCnt_q;
    bankWrite   = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (in_valid) begin
          bankWrite   = 1'b1;
          sampleCnt_d = sampleCnt_q + 3'd1;
          if (sampleCnt_q == 3'd7) begin
            state_d = ST_S1;
          end
        end
      end
      ST_S1:   state_d = ST_S2;
      ST_S2:   state_d = ST_S3;
      ST_S3:   state_d = ST_HOLD;
      ST_HOLD: begin
        if (out_ready) begin
          state_d    = ST_FILL;
          frameCnt_d = frameCnt_q + FCW'(1);
        end
      end
      default: state_d = ST_FILL;
    endcase
    if (flush) begin
      state_d     = ST_FILL;
      sampleCnt_d = '0;
      frameCnt_d  = frameCnt_q;
      bankWrite   = 1'b0;
    end
  end

  // Registered stage enables and result flag, decoded from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bf1En_q    <= 1'b0;
      bf2En_q    <= 1'b0;
      bf3En_q    <= 1'b0;
      outValid_q <= 1'b0;
    end else begin
      bf1En_q    <= (state_d == ST_S1);
      bf2En_q    <= (state_d == ST_S2);
      bf3En_q    <= (state_d == ST_S3);
      outValid_q <= (state_d == ST_HOLD);
    end
  end

  fft8_in_bank #(.DW(DW)) u_bank (
    .clk         (clk),
    .reset_n     (reset_n),
    .writeEn_i   (bankWrite),
    .writeAddr_i (bitrev3(sampleCnt_q)),
    .writeData_i (in_data),
    .bank_o      (x_buf)
  );

  assign in_ready  = (state_q == ST_FILL);
  assign busy      = (state_q != ST_FILL) || (sampleCnt_q != '0);
  assign bf1_en    = bf1En_q;
  assign bf2_en    = bf2En_q;
  assign bf3_en    = bf3En_q;
  assign out_valid = outValid_q;
  assign frame_cnt = frameCnt_q;

endmodule
